// File: rtl/ucode_pkg.sv
// ucode_pkg
// Shared definitions for the microcode sequencer and the microcode ROM image:
// sequencer state encoding, FETCH/EXEC step boundaries, the end-of-instruction
// marker word and the opcode numbering used to lay out ROM pages.
package ucode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_t;

    // Steps 0..FETCH_LAST_STEP are the common fetch sequence; opcode-specific
    // microcode starts at EXEC_FIRST_STEP.
    localparam int FETCH_LAST_STEP = 3;
    localparam int EXEC_FIRST_STEP = 4;

    // An all-zero control word in EXEC terminates the instruction.
    localparam logic [31:0] END_WORD = 32'h0000_0000;

    localparam logic [7:0] OP_LDA = 8'd0;
    localparam logic [7:0] OP_LDB = 8'd1;
    localparam logic [7:0] OP_ADD = 8'd2;

    // ROM address layout: opcode selects a page, step selects the word.
    function automatic logic [15:0] ucode_addr(input logic [7:0] opcode,
                                               input logic [7:0] step);
        return {opcode, step};
    endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if
// Microcode ROM bus between the sequencer and a combinational ROM.
//   instr_mem_addr_out : ROM address {opcode, step} driven by the sequencer
//   ctrl_word_in       : ROM data for that address, returned in the same cycle
// Modports: master = sequencer side, slave = ROM side.
interface microcode_sequencer_if #(
    parameter int STEP_W = 8
);
    logic [7+STEP_W:0] instr_mem_addr_out;
    logic [31:0]       ctrl_word_in;

    modport master (
        output instr_mem_addr_out,
        input  ctrl_word_in
    );

    modport slave (
        input  instr_mem_addr_out,
        output ctrl_word_in
    );
endinterface

// File: rtl/micro_step_counter.sv
// micro_step_counter
// Micro-step counter with synchronous clear and count enable.
//   clk, rst   : clock and synchronous active-high reset
//   clear_in   : forces the step to 0 (takes priority over enable)
//   enable_in  : advances the step by one
//   step_out   : current step
//   at_max_out : step equals MAX_STEP (last legal step)
module micro_step_counter #(
    parameter int STEP_W   = 8,
    parameter int MAX_STEP = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_in,
    input  logic              enable_in,
    output logic [STEP_W-1:0] step_out,
    output logic              at_max_out
);

    logic [STEP_W-1:0] step_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg <= '0;
        end else if (clear_in) begin
            step_reg <= '0;
        end else if (enable_in) begin
            step_reg <= step_reg + 1'b1;
        end
    end

    assign step_out   = step_reg;
    assign at_max_out = (step_reg == STEP_W'(MAX_STEP));

endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer
// Walks a microcode ROM: a shared fetch sequence (steps 0-3), then the
// opcode-specific page (steps 4+) until an all-zero end word.
//   clk, rst             : clock, synchronous active-high reset
//   run_in               : enables sequencing; sampled to leave IDLE and at
//                          instruction end
//   stall_in             : freezes step/state/opcode and zeroes the control word
//   ir_opcode_in         : opcode captured on the edge that ends step 3
//   rom                  : ROM bus (address out, combinational data in)
//   ctrl_word_out        : gated control word to the datapath
//   step_out             : current micro-step
//   instr_done_out       : pulse on a normal instruction end (step > 4)
//   illegal_op_out       : pulse when the end word appears at step 4
//   step_overflow_out    : sticky, set when the step runs past MAX_STEP
module microcode_sequencer
    import ucode_pkg::*;
#(
    parameter int STEP_W   = 8,
    parameter int MAX_STEP = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run_in,
    input  logic                        stall_in,
    input  logic [7:0]                  ir_opcode_in,
    microcode_sequencer_if.master       rom,
    output logic [31:0]                 ctrl_word_out,
    output logic [STEP_W-1:0]           step_out,
    output logic                        instr_done_out,
    output logic                        illegal_op_out,
    output logic                        step_overflow_out
);

    seq_state_t        state_reg;
    logic [7:0]        opcode_reg;
    logic              overflow_reg;

    logic [STEP_W-1:0] step;
    logic              at_max;

    logic running;
    logic advance;
    logic word_is_end;
    logic end_hit;
    logic overflow_hit;
    logic fetch_done;
    logic start;
    logic cnt_clear;

    assign running      = (state_reg != ST_IDLE);
    assign advance      = running && !stall_in;
    assign word_is_end  = (rom.ctrl_word_in == END_WORD);

    // Stall masks every detector, so no pulse can fire on a frozen cycle.
    assign end_hit      = advance && (state_reg == ST_EXEC) && word_is_end;
    assign overflow_hit = advance && (state_reg == ST_EXEC) && !word_is_end && at_max;
    assign fetch_done   = advance && (state_reg == ST_FETCH) &&
                          (step == STEP_W'(FETCH_LAST_STEP));
    assign start        = (state_reg == ST_IDLE) && run_in && !stall_in;

    // Holding the counter cleared in IDLE guarantees FETCH begins at step 0.
    assign cnt_clear    = (state_reg == ST_IDLE) || end_hit || overflow_hit;

    micro_step_counter #(
        .STEP_W   (STEP_W),
        .MAX_STEP (MAX_STEP)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .clear_in   (cnt_clear),
        .enable_in  (advance),
        .step_out   (step),
        .at_max_out (at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            opcode_reg   <= 8'h00;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // The opcode is only captured here, keeping the ROM page
                    // stable for the whole EXEC phase.
                    if (fetch_done) begin
                        opcode_reg <= ir_opcode_in;
                        state_reg  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (end_hit) begin
                        state_reg <= run_in ? ST_FETCH : ST_IDLE;
                    end else if (overflow_hit) begin
                        state_reg    <= ST_FETCH;
                        overflow_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom.instr_mem_addr_out = {opcode_reg, step};

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ctrl_gate
            assign ctrl_word_out[gi] = advance & rom.ctrl_word_in[gi];
        end
    endgenerate

    assign step_out          = step;
    assign instr_done_out    = end_hit && (step > STEP_W'(EXEC_FIRST_STEP));
    assign illegal_op_out    = end_hit && (step == STEP_W'(EXEC_FIRST_STEP));
    assign step_overflow_out = overflow_reg;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;
    import ucode_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_in;
    logic       stall_in;
    logic [7:0] ir;

    always #5 clk = ~clk;

    microcode_sequencer_if #(.STEP_W(8)) rom_a();
    microcode_sequencer_if #(.STEP_W(8)) rom_b();

    logic [31:0] ctrl_a, ctrl_b;
    logic [7:0]  step_a, step_b;
    logic        done_a, done_b, ill_a, ill_b, ovf_a, ovf_b;

    microcode_sequencer dut_a (
        .clk               (clk),
        .rst               (rst),
        .run_in            (run_in),
        .stall_in          (stall_in),
        .ir_opcode_in      (ir),
        .rom               (rom_a),
        .ctrl_word_out     (ctrl_a),
        .step_out          (step_a),
        .instr_done_out    (done_a),
        .illegal_op_out    (ill_a),
        .step_overflow_out (ovf_a)
    );

    microcode_sequencer #(.STEP_W(8), .MAX_STEP(8)) dut_b (
        .clk               (clk),
        .rst               (rst),
        .run_in            (run_in),
        .stall_in          (stall_in),
        .ir_opcode_in      (ir),
        .rom               (rom_b),
        .ctrl_word_out     (ctrl_b),
        .step_out          (step_b),
        .instr_done_out    (done_b),
        .illegal_op_out    (ill_b),
        .step_overflow_out (ovf_b)
    );

    // ROM image A: LDA ends at 6, LDB at 7, ADD at 5, opcode 7 has no code.
    // Word at 0x0001 is zero to exercise the ignored zero in FETCH.
    function automatic logic [31:0] rom_word(input logic [15:0] a);
        logic [7:0]  op;
        logic [7:0]  s;
        logic [31:0] w;
        op = a[15:8];
        s  = a[7:0];
        w  = {op, 8'hC3, 8'h00, s};
        if (op == OP_LDA && s == 8'd1) w = 32'h0;
        if (op == OP_LDA && s == 8'd6) w = 32'h0;
        if (op == OP_LDB && s == 8'd7) w = 32'h0;
        if (op == OP_ADD && s == 8'd4) w = 32'h8840_004A;
        if (op == OP_ADD && s == 8'd5) w = 32'h0;
        if (op == 8'h07  && s == 8'd4) w = 32'h0;
        return w;
    endfunction

    // ROM image B never contains an end word.
    function automatic logic [31:0] rom_b_word(input logic [15:0] a);
        return {a, 16'h5A5A};
    endfunction

    assign rom_a.ctrl_word_in = rom_word(rom_a.instr_mem_addr_out);
    assign rom_b.ctrl_word_in = rom_b_word(rom_b.instr_mem_addr_out);

    typedef struct {
        int          idx;
        logic [15:0] addr;
        logic [31:0] ctrl;
        logic [7:0]  step;
        logic        done;
        logic        ill;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    bit   sel_b  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, push the expected outputs for this cycle,
    // compare at the falling edge, then let the rising edge commit.
    task automatic cyc(input logic r, input logic rn, input logic st,
                       input logic [7:0] op, input logic act,
                       input logic [15:0] a, input logic [7:0] s,
                       input logic d, input logic il, input logic ov);
        exp_t        e;
        logic [15:0] o_addr;
        logic [31:0] o_ctrl;
        logic [7:0]  o_step;
        logic        o_done, o_ill, o_ovf;
        rst      = r;
        run_in   = rn;
        stall_in = st;
        ir       = op;
        e.idx  = ncyc;
        e.addr = a;
        e.step = s;
        e.done = d;
        e.ill  = il;
        e.ovf  = ov;
        e.ctrl = (act && !st) ? (sel_b ? rom_b_word(a) : rom_word(a)) : 32'h0;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        o_addr = sel_b ? rom_b.instr_mem_addr_out : rom_a.instr_mem_addr_out;
        o_ctrl = sel_b ? ctrl_b : ctrl_a;
        o_step = sel_b ? step_b : step_a;
        o_done = sel_b ? done_b : done_a;
        o_ill  = sel_b ? ill_b  : ill_a;
        o_ovf  = sel_b ? ovf_b  : ovf_a;
        $display("cyc %0d dut=%s addr=%h step=%0d ctrl=%h done=%b ill=%b ovf=%b",
                 e.idx, sel_b ? "b" : "a", o_addr, o_step, o_ctrl, o_done, o_ill, o_ovf);
        check_val($sformatf("addr@%0d", e.idx), 32'(o_addr), 32'(e.addr));
        check_val($sformatf("ctrl@%0d", e.idx), o_ctrl, e.ctrl);
        check_val($sformatf("step@%0d", e.idx), 32'(o_step), 32'(e.step));
        check_val($sformatf("done@%0d", e.idx), 32'(o_done), 32'(e.done));
        check_val($sformatf("illegal@%0d", e.idx), 32'(o_ill), 32'(e.ill));
        check_val($sformatf("overflow@%0d", e.idx), 32'(o_ovf), 32'(e.ovf));
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    initial begin
        rst      = 1'b1;
        run_in   = 1'b0;
        stall_in = 1'b0;
        ir       = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, IDLE hold, then start
        cyc(0, 0, 0, 8'h00, 0, 16'h0000, 8'd0, 0, 0, 0);
        cyc(0, 1, 0, 8'h00, 0, 16'h0000, 8'd0, 0, 0, 0);

        // LDA: 0x0000..0x0006, done at step 6
        for (int s = 0; s <= 6; s++)
            cyc(0, 1, 0, OP_LDA, 1, {8'h00, 8'(s)}, 8'(s), (s == 6), 0, 0);

        // ADD: refetch from 0x0000, EXEC at 0x0204, done at step 5
        for (int s = 0; s <= 3; s++)
            cyc(0, 1, 0, OP_ADD, 1, {8'h00, 8'(s)}, 8'(s), 0, 0, 0);
        cyc(0, 1, 0, OP_ADD, 1, 16'h0204, 8'd4, 0, 0, 0);
        cyc(0, 1, 0, OP_ADD, 1, 16'h0205, 8'd5, 1, 0, 0);

        // Illegal opcode 7: end word at step 4
        for (int s = 0; s <= 3; s++)
            cyc(0, 1, 0, 8'h07, 1, {8'h02, 8'(s)}, 8'(s), 0, 0, 0);
        cyc(0, 1, 0, 8'h07, 1, 16'h0704, 8'd4, 0, 1, 0);

        // LDB with a 3-cycle stall at step 2, then reset at step 5
        cyc(0, 1, 0, OP_LDB, 1, 16'h0700, 8'd0, 0, 0, 0);
        cyc(0, 1, 0, OP_LDB, 1, 16'h0701, 8'd1, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 1, OP_LDB, 1, 16'h0702, 8'd2, 0, 0, 0);
        cyc(0, 1, 0, OP_LDB, 1, 16'h0702, 8'd2, 0, 0, 0);
        cyc(0, 1, 0, OP_LDB, 1, 16'h0703, 8'd3, 0, 0, 0);
        cyc(0, 1, 0, OP_LDB, 1, 16'h0104, 8'd4, 0, 0, 0);
        cyc(1, 1, 0, OP_LDB, 1, 16'h0105, 8'd5, 0, 0, 0);
        cyc(0, 0, 0, OP_LDB, 0, 16'h0000, 8'd0, 0, 0, 0);

        // run_in drops mid-instruction; stall on the end-word cycle
        cyc(0, 1, 0, OP_ADD, 0, 16'h0000, 8'd0, 0, 0, 0);
        cyc(0, 1, 0, OP_ADD, 1, 16'h0000, 8'd0, 0, 0, 0);
        for (int s = 1; s <= 3; s++)
            cyc(0, 0, 0, OP_ADD, 1, {8'h00, 8'(s)}, 8'(s), 0, 0, 0);
        cyc(0, 0, 0, OP_ADD, 1, 16'h0204, 8'd4, 0, 0, 0);
        cyc(0, 0, 1, OP_ADD, 1, 16'h0205, 8'd5, 0, 0, 0);
        cyc(0, 0, 0, OP_ADD, 1, 16'h0205, 8'd5, 1, 0, 0);
        cyc(0, 0, 0, OP_ADD, 0, 16'h0200, 8'd0, 0, 0, 0);
        cyc(0, 0, 0, OP_ADD, 0, 16'h0200, 8'd0, 0, 0, 0);

        // Overflow on the MAX_STEP=8 instance
        sel_b  = 1'b1;
        rst    = 1'b1;
        run_in = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 8'h03, 0, 16'h0000, 8'd0, 0, 0, 0);
        cyc(0, 1, 0, 8'h03, 0, 16'h0000, 8'd0, 0, 0, 0);
        for (int s = 0; s <= 3; s++)
            cyc(0, 1, 0, 8'h03, 1, {8'h00, 8'(s)}, 8'(s), 0, 0, 0);
        for (int s = 4; s <= 8; s++)
            cyc(0, 1, 0, 8'h03, 1, {8'h03, 8'(s)}, 8'(s), 0, 0, 0);
        for (int s = 0; s <= 2; s++)
            cyc(0, 1, 0, 8'h03, 1, {8'h03, 8'(s)}, 8'(s), 0, 0, 1);
        cyc(1, 1, 0, 8'h03, 1, 16'h0303, 8'd3, 0, 0, 1);
        cyc(0, 0, 0, 8'h03, 0, 16'h0000, 8'd0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter STEP_W, default 8, micro-step counter width.
REQ-002 SHALL have parameter MAX_STEP, default 255, last legal step before overflow error.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run_in  input  1  high enables sequencing; low in IDLE holds IDLE.
REQ-006 SHALL have port stall_in  input  1  holds step, state and opcode; gates control word to zero.
REQ-007 SHALL have port ir_opcode_in  input  8  opcode field from instruction register.
REQ-008 SHALL have port ctrl_word_in  input  32  microcode ROM data for the current address (combinational ROM).
REQ-009 SHALL have port instr_mem_addr_out  output  16  ROM address {opcode_reg, step}.
REQ-010 SHALL have port ctrl_word_out  output  32  control word to datapath.
REQ-011 SHALL have port step_out  output  8  current micro-step.
REQ-012 SHALL have port instr_done_out  output  1  one-cycle pulse on normal instruction end.
REQ-013 SHALL have port illegal_op_out  output  1  one-cycle pulse on opcode with no microcode.
REQ-014 SHALL have port step_overflow_out  output  1  sticky flag; set when step passes MAX_STEP.

Function
REQ-015 SHALL implement states IDLE, FETCH (steps 0-3), EXEC (steps >= 4).
REQ-016 SHALL drive instr_mem_addr_out = {opcode_reg, step} combinationally in every state.
REQ-017 SHALL drive ctrl_word_out = ctrl_word_in in FETCH/EXEC when stall_in low; all-zero in IDLE or when stall_in high.
REQ-018 SHALL transition IDLE->FETCH, step 0, on the edge where run_in is high.
REQ-019 SHALL increment step by 1 per non-stalled cycle in FETCH and EXEC.
REQ-020 SHALL load opcode_reg from ir_opcode_in at the edge ending step 3, and enter EXEC with step 4.
REQ-021 SHALL treat ctrl_word_in == 32'h0 in EXEC as the end marker: next step 0, state FETCH (IDLE if run_in low).
REQ-022 SHALL pulse instr_done_out in the end-marker cycle when step > 4.
REQ-023 SHALL pulse illegal_op_out instead of instr_done_out when the end marker occurs at step 4; same transition as REQ-021.
REQ-024 SHALL ignore an all-zero word during FETCH, with no early exit.
REQ-025 SHALL, in EXEC at step == MAX_STEP with a non-zero word, wrap to step 0 in FETCH and set step_overflow_out.
REQ-026 SHALL give stall_in priority over end-marker and overflow detection: no pulses while stalled.
REQ-027 SHALL keep opcode_reg unchanged outside the step-3 load edge, so the address high byte is stable through EXEC.
REQ-028 SHALL finish the current instruction when run_in drops mid-instruction, then enter IDLE.

Reset
REQ-029 SHALL, while rst is high at an edge, set state IDLE, step 0, opcode_reg 0, step_overflow_out 0, with outputs instr_mem_addr_out 0, ctrl_word_out 0, instr_done_out 0, illegal_op_out 0.
REQ-030 SHALL make rst override run_in, stall_in and any mid-instruction state; the instruction is abandoned.

Structure
REQ-031 SHALL place state encoding, FETCH_LAST_STEP=3, EXEC_FIRST_STEP=4, END_WORD=32'h0 and opcodes LDA=0, LDB=1, ADD=2 in shared package ucode_pkg, also used by the ROM.
REQ-032 SHALL implement the step counter (clear, enable, overflow compare) as sub-module micro_step_counter.

Verification
REQ-033 SHALL cover LDA: rst, run_in=1, ir_opcode_in=0, ROM end at step 6 -> addresses 0x0000..0x0006, instr_done_out pulse at step 6, next cycle address 0x0000.
REQ-034 SHALL cover ADD: opcode 2 -> address 0x0204 in EXEC with ctrl_word_out 32'h88400 04A, done at step 5, then refetch.
REQ-035 SHALL cover illegal op: ir_opcode_in=8'h07 -> address 0x0704 with zero word, illegal_op_out pulse, no instr_done_out, step 0 next.
REQ-036 SHALL cover stall: stall_in=1 for 3 cycles at step 2 -> step_out stays 2, ctrl_word_out 0; resume at step 3 next.
REQ-037 SHALL cover reset: rst at step 5 of LDB -> next cycle IDLE, all outputs 0, step_overflow_out 0.
REQ-038 SHALL cover overflow: MAX_STEP=8, ROM never zero -> at step 8 wrap to 0, step_overflow_out stays 1 until rst.
